// File: rtl/display_pkg.sv
// Shared display types for the framebuffer pixel path.
//   rgb565_t         : framebuffer word {r5, g6, b5}
//   rgb888_t         : stream pixel {r8, g8, b8}
//   streamer_state_e : scan-out controller states
//   rgb565_to_888    : colour expansion by MSB replication
package display_pkg;

  localparam int DEFAULT_WIDTH  = 320;
  localparam int DEFAULT_HEIGHT = 240;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    STREAM    = 2'd2,
    DRAIN     = 2'd3
  } streamer_state_e;

  // Replicating the top bits into the new LSBs maps full-scale to full-scale
  // (0x1F -> 0xFF) and zero to zero, with no multiplier.
  function automatic rgb888_t rgb565_to_888(input rgb565_t p);
    rgb888_t q;
    q.r = {p.r, p.r[4:2]};
    q.g = {p.g, p.g[5:4]};
    q.b = {p.b, p.b[4:2]};
    return q;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with the head entry visible combinationally.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write data_i (ignored when full unless popping too)
//   pop_i        : remove the head entry (ignored when empty)
//   data_o       : head entry, valid while empty_o is low
//   empty_o      : no entries
//   full_o       : DEPTH entries
//   count_o      : number of entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH_BITS = 16,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [WIDTH_BITS-1:0] data_i,
  input  logic                  pop_i,
  output logic [WIDTH_BITS-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [WIDTH_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count_q alone says which entries
  // are live, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fb_pixel_streamer.sv
// Scans one framebuffer frame out of a 1-cycle-latency RAM per toggle of the
// display's frame index and presents it as an RGB888 valid/ready stream.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   enable_i       : allows new frames to start
//   frame_idx_i    : each toggle requests one frame
//   fb_rd_en_o     : framebuffer read strobe
//   fb_addr_o      : framebuffer word address (0 when not reading)
//   fb_rdata_i     : RGB565 word, valid one cycle after fb_rd_en_o
//   pixel_valid_o  : pixel available
//   pixel_ready_i  : sink accepts pixel
//   pixel_data_o   : {R8, G8, B8}
//   busy_o         : a frame is being read or drained
//   frame_done_o   : pulse when the last pixel of a frame is accepted
//   overrun_o      : sticky, a toggle arrived while busy
module fb_pixel_streamer
  import display_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int HEIGHT     = DEFAULT_HEIGHT,
  parameter int ADDR_W     = 17,
  parameter int FB_BASE    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              frame_idx_i,
  output logic              fb_rd_en_o,
  output logic [ADDR_W-1:0] fb_addr_o,
  input  logic [15:0]       fb_rdata_i,
  output logic              pixel_valid_o,
  input  logic              pixel_ready_i,
  output logic [23:0]       pixel_data_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              overrun_o
);

  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int CNT_W  = $clog2(NPIX + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam longint unsigned FB_END = longint'(FB_BASE) + longint'(NPIX);

  if (FB_END > (64'd1 << ADDR_W)) begin : g_addr_range_check
    $error("fb_pixel_streamer: FB_BASE + WIDTH*HEIGHT exceeds 2**ADDR_W");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("fb_pixel_streamer: FIFO_DEPTH must be a power of two >= 2");
  end

  streamer_state_e   state_q, state_d;
  logic              frame_idx_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]  rd_cnt_q,  rd_cnt_d;
  logic              inflight_q;
  logic              overrun_q, overrun_d;

  logic              tog, busy, issue, pop, last_xfer, done;
  logic              fifo_empty, fifo_full;
  logic [FCNT_W-1:0] fifo_count, occ_after_pop;
  logic              credit_ok, more_to_read;
  rgb565_t           head;

  sync_fifo #(
    .WIDTH_BITS (16),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .data_i  (fb_rdata_i),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign tog  = frame_idx_i ^ frame_idx_q;
  assign busy = (state_q == STREAM) || (state_q == DRAIN);
  assign pop  = !fifo_empty && pixel_ready_i;

  // Credit counts the in-flight read as already occupying a slot and frees
  // the slot being popped this cycle, so a full FIFO can refill back-to-back.
  assign occ_after_pop = fifo_count - FCNT_W'(pop);
  assign credit_ok     = ({1'b0, occ_after_pop} + (FCNT_W + 1)'(inflight_q))
                         < (FCNT_W + 1)'(FIFO_DEPTH);
  assign more_to_read  = rd_cnt_q < CNT_W'(NPIX);

  // Last pixel of the frame: nothing left in flight and one entry leaving.
  assign last_xfer = pop && !inflight_q && (fifo_count == FCNT_W'(1));

  // NOTE: every signal driven here gets a default before the case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_cnt_d  = rd_cnt_q;
    issue     = 1'b0;
    done      = 1'b0;
    overrun_d = overrun_q | (tog & busy);
    unique case (state_q)
      IDLE: begin
        if (enable_i) state_d = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (tog) begin
          state_d   = STREAM;
          rd_addr_d = ADDR_W'(FB_BASE);
          rd_cnt_d  = '0;
        end
      end
      STREAM: begin
        issue = credit_ok && more_to_read;
        if (issue) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          rd_cnt_d  = rd_cnt_q + CNT_W'(1);
        end
        if (rd_cnt_d == CNT_W'(NPIX)) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_xfer) begin
          done    = 1'b1;
          state_d = enable_i ? WAIT_SYNC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    frame_idx_q <= frame_idx_i;
    if (rst_i) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      rd_cnt_q   <= '0;
      inflight_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      inflight_q <= issue;
      overrun_q  <= overrun_d;
    end
  end

  assign fb_rd_en_o    = issue;
  assign fb_addr_o     = issue ? rd_addr_q : '0;
  assign pixel_valid_o = !fifo_empty;
  assign pixel_data_o  = rgb565_to_888(head);
  assign busy_o        = busy;
  assign frame_done_o  = done;
  assign overrun_o     = overrun_q;

  // The credit rule must keep a returning read from landing on a full FIFO.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inflight_q && fifo_full && !pop));

endmodule

// File: tb/tb_fb_pixel_streamer.sv
// Self-checking bench for fb_pixel_streamer on a small 8x6 frame at a
// non-zero base. A behavioural model derives the expected pixel sequence
// from RAM contents; a monitor checks reads, pixels, stalls and frame_done.
module tb_fb_pixel_streamer;

  localparam int W     = 8;
  localparam int H     = 6;
  localparam int AW    = 8;
  localparam int BASE  = 16;
  localparam int DEPTH = 4;
  localparam int N     = W * H;

  logic          clk = 1'b0;
  logic          rst, enable, frame_idx;
  logic          fb_rd_en;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_rdata = '0;
  logic          valid, ready;
  logic [23:0]   data;
  logic          busy, done, overrun;

  logic [15:0] ram [256];

  int          total = 0;
  int          bad   = 0;
  logic [23:0] exp_q [$];
  int          rd_left = 0;
  int          rd_idx = 0;
  int          xfer_in_frame = 0;
  logic        done_seen = 1'b0;
  logic        rand_ready = 1'b0;
  logic [23:0] got [N];
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [23:0] prev_data = '0;
  int          cyc;
  int          n;

  fb_pixel_streamer #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .ADDR_W     (AW),
    .FB_BASE    (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .frame_idx_i   (frame_idx),
    .fb_rd_en_o    (fb_rd_en),
    .fb_addr_o     (fb_addr),
    .fb_rdata_i    (fb_rdata),
    .pixel_valid_o (valid),
    .pixel_ready_i (ready),
    .pixel_data_o  (data),
    .busy_o        (busy),
    .frame_done_o  (done),
    .overrun_o     (overrun)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (fb_rd_en) fb_rdata <= ram[fb_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, want);
    end
  endtask

  // 5/6-bit channel to 8 bits: shift up, fill the low bits with the top bits.
  function automatic logic [23:0] ref_px(input logic [15:0] w);
    int r5, g6, b5;
    logic [7:0] r8, g8, b8;
    r5 = int'(w[15:11]);
    g6 = int'(w[10:5]);
    b5 = int'(w[4:0]);
    r8 = 8'(r5 * 8 + r5 / 4);
    g8 = 8'(g6 * 4 + g6 / 16);
    b8 = 8'(b5 * 8 + b5 / 4);
    return {r8, g8, b8};
  endfunction

  task automatic tick();
    @(negedge clk);
    ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic start_frame();
    for (int i = 0; i < N; i++) exp_q.push_back(ref_px(ram[BASE + i]));
    rd_left       = N;
    rd_idx        = 0;
    xfer_in_frame = 0;
    done_seen     = 1'b0;
  endtask

  task automatic flush_model();
    exp_q.delete();
    rd_left       = 0;
    rd_idx        = 0;
    xfer_in_frame = 0;
    prev_valid    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done_seen && cycles < budget) begin
      tick();
      #3;
      cycles++;
    end
    check("done_timeout", 32'(done_seen), 32'd1);
  endtask

  // Monitor: samples 2 time units after each falling edge, once the bench
  // has driven that cycle's inputs.
  always begin
    logic        xfer;
    logic        exp_done;
    logic [23:0] want;
    @(negedge clk);
    #2;
    xfer     = valid && ready;
    exp_done = xfer && (exp_q.size() == 1);
    if (prev_valid && !prev_ready) begin
      check("stall_valid", 32'(valid), 32'd1);
      check("stall_data", 32'(data), 32'(prev_data));
    end
    if (fb_rd_en) begin
      if (rd_left == 0) begin
        check("spurious_rd", 32'd1, 32'd0);
      end else begin
        check("rd_addr", 32'(fb_addr), 32'(BASE + rd_idx));
        rd_idx++;
        rd_left--;
      end
    end
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check("spurious_pix", 32'd1, 32'd0);
      end else begin
        want = exp_q.pop_front();
        check("pix", 32'(data), 32'(want));
        if (xfer_in_frame < N) got[xfer_in_frame] = data;
        xfer_in_frame++;
      end
    end
    if (fb_rd_en) check("credit", 32'(rd_idx - xfer_in_frame <= DEPTH), 32'd1);
    if (xfer || done) check("frame_done", 32'(done), 32'(exp_done));
    if (done) done_seen = 1'b1;
    prev_valid = valid;
    prev_ready = ready;
    prev_data  = data;
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    frame_idx = 1'b0;
    ready     = 1'b1;
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    for (int i = 0; i < N; i++) ram[BASE + i] = 16'(i);

    // Reset state
    tick();
    tick();
    rst    = 1'b0;
    enable = 1'b1;
    #3;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_rd_en", 32'(fb_rd_en), 32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Frame 1: ramp data, ready held high, latency and throughput
    tick();
    start_frame();
    frame_idx = ~frame_idx;
    #3;
    check("t0_rd_en", 32'(fb_rd_en), 32'd0);
    tick(); #3;
    check("t1_rd_en", 32'(fb_rd_en), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    tick(); #3;
    check("t2_valid", 32'(valid), 32'd0);
    tick(); #3;
    check("t3_valid", 32'(valid), 32'd1);
    wait_done(200, cyc);
    check("f1_latency", 32'(3 + cyc), 32'(N + 2));
    check("f1_px7", 32'(got[7]), 32'h000039);
    tick(); #3;
    check("f1_idle_busy", 32'(busy), 32'd0);
    check("f1_idle_valid", 32'(valid), 32'd0);

    // Frame 2: colour corners, toggle coinciding with frame_done
    ram[BASE + 0] = 16'hF800;
    ram[BASE + 1] = 16'h07E0;
    ram[BASE + 2] = 16'h001F;
    ram[BASE + 3] = 16'hFFFF;
    ram[BASE + 4] = 16'h8410;
    for (int i = 5; i < N; i++) ram[BASE + i] = 16'($urandom);
    start_frame();
    frame_idx = ~frame_idx;
    n = 0;
    while (exp_q.size() > 1 && n < 500) begin
      tick(); #3;
      n++;
    end
    tick();
    ready = 1'b0;
    #3;
    while (!valid && n < 500) begin
      tick();
      ready = 1'b0;
      #3;
      n++;
    end
    tick();
    frame_idx = ~frame_idx;
    #3;
    check("coll_done", 32'(done), 32'd1);
    check("coll_overrun_pre", 32'(overrun), 32'd0);
    tick(); #3;
    check("coll_overrun", 32'(overrun), 32'd1);
    check("coll_busy", 32'(busy), 32'd0);
    repeat (10) tick();
    #3;
    check("coll_no_frame", 32'(valid), 32'd0);
    check("corner_red", 32'(got[0]), 32'hFF0000);
    check("corner_green", 32'(got[1]), 32'h00FF00);
    check("corner_blue", 32'(got[2]), 32'h0000FF);
    check("corner_white", 32'(got[3]), 32'hFFFFFF);
    check("corner_mid", 32'(got[4]), 32'h848284);

    // Reset clears the sticky overrun
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #3;
    check("rst_overrun_clr", 32'(overrun), 32'd0);
    tick();

    // Frame 3: random stalls, extra toggle mid-frame
    rand_ready = 1'b1;
    for (int i = 0; i < N; i++) ram[BASE + i] = 16'($urandom);
    tick();
    start_frame();
    frame_idx = ~frame_idx;
    repeat (12) tick();
    frame_idx = ~frame_idx;
    #3;
    check("mid_busy", 32'(busy), 32'd1);
    tick(); #3;
    check("mid_overrun", 32'(overrun), 32'd1);
    wait_done(2000, cyc);
    check("f3_count", 32'(xfer_in_frame), 32'(N));
    check("f3_overrun_sticky", 32'(overrun), 32'd1);
    tick(); #3;
    check("f3_busy_after", 32'(busy), 32'd0);

    // Frame 4: fresh toggle from WAIT_SYNC starts a new frame
    for (int i = 0; i < N; i++) ram[BASE + i] = 16'($urandom);
    tick();
    start_frame();
    frame_idx = ~frame_idx;
    wait_done(2000, cyc);
    check("f4_count", 32'(xfer_in_frame), 32'(N));

    // Frame 5: reset after 5 pixels
    tick();
    start_frame();
    frame_idx = ~frame_idx;
    n = 0;
    while (xfer_in_frame < 5 && n < 500) begin
      tick(); #3;
      n++;
    end
    check("f5_reached_5", 32'(xfer_in_frame), 32'd5);
    tick();
    rst   = 1'b1;
    ready = 1'b0;
    tick();
    rst = 1'b0;
    flush_model();
    #3;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_rd_en", 32'(fb_rd_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    repeat (15) tick();
    #3;
    check("mid_rst_quiet", 32'(valid), 32'd0);

    // Frame 6: enable dropped mid-frame, frame completes, then IDLE
    tick();
    start_frame();
    frame_idx = ~frame_idx;
    repeat (6) tick();
    enable = 1'b0;
    wait_done(2000, cyc);
    check("f6_count", 32'(xfer_in_frame), 32'(N));
    tick(); #3;
    check("f6_busy_after", 32'(busy), 32'd0);
    frame_idx = ~frame_idx;
    repeat (20) tick();
    #3;
    check("f6_no_restart_valid", 32'(valid), 32'd0);
    check("f6_no_restart_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
